// File: rtl/avr_io_pkg.sv
// Shared UART register addresses, status/control bit positions and FSM state types.
package avr_io_pkg;

  localparam int unsigned IO_AW         = 6;
  localparam int unsigned DW            = 8;
  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned TCNT_W        = 4;
  localparam int unsigned BCNT_W        = 3;

  localparam logic [IO_AW-1:0] ADDR_UDR   = 6'h0C;
  localparam logic [IO_AW-1:0] ADDR_UCSRA = 6'h0B;
  localparam logic [IO_AW-1:0] ADDR_UCSRB = 6'h0A;
  localparam logic [IO_AW-1:0] ADDR_UBRR  = 6'h09;

  // UCSRA
  localparam int unsigned RXC_BIT  = 7;
  localparam int unsigned TXC_BIT  = 6;
  localparam int unsigned UDRE_BIT = 5;
  localparam int unsigned FE_BIT   = 4;
  localparam int unsigned DOR_BIT  = 3;
  // UCSRB
  localparam int unsigned RXEN_BIT = 4;
  localparam int unsigned TXEN_BIT = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/avr_uart_baud.sv
// Baud prescaler: one-clock tick every ubrr+1 clocks, restarted when UBRR is written.
module avr_uart_baud
  import avr_io_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ubrr,
  input  logic          reload,
  output logic          tick
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == ubrr);
      cnt  <= (cnt == ubrr) ? '0 : cnt + DW'(1);
    end
  end

endmodule

// File: rtl/avr_uart.sv
// AVR-style UART: CPU register file, 8N1 transmitter and optional receiver.
// Define AVR_UART_RX_EN to compile in the receiver; the default build is TX-only.
module avr_uart
  import avr_io_pkg::*;
#(
  parameter logic [DW-1:0] UBRR_INIT   = 8'd0,
  parameter int unsigned   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IO_AW-1:0] io_addr,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [DW-1:0]    io_din,
  output logic [DW-1:0]    io_dout,
  input  logic             rx,
  output logic             tx
);

  logic wr_udr, wr_ucsra, wr_ucsrb, wr_ubrr;
  logic txen, tick;
  logic [DW-1:0] ubrr;
  logic rxen, rxc, fe, dor;
  logic [DW-1:0] rbuf;

  assign wr_udr   = io_write && (io_addr == ADDR_UDR);
  assign wr_ucsra = io_write && (io_addr == ADDR_UCSRA);
  assign wr_ucsrb = io_write && (io_addr == ADDR_UCSRB);
  assign wr_ubrr  = io_write && (io_addr == ADDR_UBRR);

  always_ff @(posedge clk) begin
    if (rst) begin
      txen <= 1'b0;
      ubrr <= UBRR_INIT;
    end else begin
      if (wr_ucsrb) txen <= io_din[TXEN_BIT];
      if (wr_ubrr)  ubrr <= io_din;
    end
  end

  avr_uart_baud u_baud (
    .clk    (clk),
    .rst    (rst),
    .ubrr   (ubrr),
    .reload (wr_ubrr),
    .tick   (tick)
  );

  // Transmitter: holding register (thr/udre) feeding a shifter
  tx_state_e tx_state, tx_state_d;
  logic [TCNT_W-1:0] tx_tcnt, tx_tcnt_d;
  logic [BCNT_W-1:0] tx_bcnt, tx_bcnt_d;
  logic [DW-1:0] tx_shift, tx_shift_d, thr, thr_d;
  logic tx_d, udre, udre_d, txc, txc_d, tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == TCNT_W'(TICKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      thr      <= '0;
      tx       <= 1'b1;
      udre     <= 1'b1;
      txc      <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_tcnt  <= tx_tcnt_d;
      tx_bcnt  <= tx_bcnt_d;
      tx_shift <= tx_shift_d;
      thr      <= thr_d;
      tx       <= tx_d;
      udre     <= udre_d;
      txc      <= txc_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_tcnt_d  = tx_tcnt;
    tx_bcnt_d  = tx_bcnt;
    tx_shift_d = tx_shift;
    thr_d      = thr;
    tx_d       = tx;
    udre_d     = udre;
    txc_d      = txc;
    if (wr_ucsra && io_din[TXC_BIT]) txc_d = 1'b0;
    if (wr_udr && udre && txen) begin
      thr_d  = io_din;
      udre_d = 1'b0;
    end
    if (tick) tx_tcnt_d = tx_tcnt + TCNT_W'(1);
    case (tx_state)
      TX_IDLE: begin
        tx_d      = 1'b1;
        tx_tcnt_d = '0;
        if (!udre && txen) begin
          tx_shift_d = thr;
          udre_d     = 1'b1;
          tx_bcnt_d  = '0;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_d       = tx_shift[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bcnt == BCNT_W'(DW - 1)) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = tx_shift >> 1;
            tx_d       = tx_shift[1];
            tx_bcnt_d  = tx_bcnt + BCNT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          txc_d = 1'b1;
          // A full holding register starts the next frame with no idle gap
          if (!udre && txen) begin
            tx_shift_d = thr;
            udre_d     = 1'b1;
            tx_bcnt_d  = '0;
            tx_d       = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

`ifdef AVR_UART_RX_EN
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  rx_state_e rx_state, rx_state_d;
  logic [SYNC_N-1:0] rx_sync;
  logic [TCNT_W-1:0] rx_tcnt, rx_tcnt_d;
  logic [BCNT_W-1:0] rx_bcnt, rx_bcnt_d;
  logic [DW-1:0] rx_shift, rx_shift_d, rbuf_d;
  logic rx_s, rx_prev, rxc_d, fe_d, dor_d, rx_done, rx_mid, rx_end, rd_udr;

  assign rx_s   = rx_sync[SYNC_N-1];
  assign rd_udr = io_read && (io_addr == ADDR_UDR);
  assign rx_mid = tick && (rx_tcnt == TCNT_W'(TICKS_PER_BIT / 2 - 1));
  assign rx_end = tick && (rx_tcnt == TCNT_W'(TICKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rxen     <= 1'b0;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      rbuf     <= '0;
      rxc      <= 1'b0;
      fe       <= 1'b0;
      dor      <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[SYNC_N-2:0], rx};
      rx_prev  <= rx_s;
      if (wr_ucsrb) rxen <= io_din[RXEN_BIT];
      rx_state <= rx_state_d;
      rx_tcnt  <= rx_tcnt_d;
      rx_bcnt  <= rx_bcnt_d;
      rx_shift <= rx_shift_d;
      rbuf     <= rbuf_d;
      rxc      <= rxc_d;
      fe       <= fe_d;
      dor      <= dor_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_tcnt_d  = rx_tcnt;
    rx_bcnt_d  = rx_bcnt;
    rx_shift_d = rx_shift;
    rbuf_d     = rbuf;
    rxc_d      = rxc;
    fe_d       = fe;
    dor_d      = dor;
    rx_done    = 1'b0;
    if (tick) rx_tcnt_d = rx_tcnt + TCNT_W'(1);
    case (rx_state)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        rx_bcnt_d = '0;
        if (rx_prev && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_mid && rx_s) rx_state_d = RX_IDLE;
        else if (rx_end)    rx_state_d = RX_DATA;
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_d = {rx_s, rx_shift[DW-1:1]};
        if (rx_end) begin
          if (rx_bcnt == BCNT_W'(DW - 1)) rx_state_d = RX_STOP;
          else                            rx_bcnt_d  = rx_bcnt + BCNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_mid) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // Disabling the receiver abandons any frame in flight without touching flags
    if (!rxen) begin
      rx_state_d = RX_IDLE;
      rx_done    = 1'b0;
    end
    if (rd_udr) begin
      rxc_d = 1'b0;
      fe_d  = 1'b0;
      dor_d = 1'b0;
    end
    if (rx_done) begin
      if (rxc && !rd_udr) begin
        dor_d = 1'b1;
      end else begin
        rbuf_d = rx_shift;
        rxc_d  = 1'b1;
        fe_d   = !rx_s;
        dor_d  = 1'b0;
      end
    end
  end
`else
  logic unused_rx;
  assign rxen      = 1'b0;
  assign rxc       = 1'b0;
  assign fe        = 1'b0;
  assign dor       = 1'b0;
  assign rbuf      = '0;
  assign unused_rx = ^{io_read, rx, 1'(SYNC_STAGES)};
`endif

  // CPU read mux
  always_comb begin
    io_dout = '0;
    case (io_addr)
      ADDR_UDR: io_dout = rbuf;
      ADDR_UCSRA: begin
        io_dout[RXC_BIT]  = rxc;
        io_dout[TXC_BIT]  = txc;
        io_dout[UDRE_BIT] = udre;
        io_dout[FE_BIT]   = fe;
        io_dout[DOR_BIT]  = dor;
      end
      ADDR_UCSRB: begin
        io_dout[RXEN_BIT] = rxen;
        io_dout[TXEN_BIT] = txen;
      end
      ADDR_UBRR: io_dout = ubrr;
      default:   io_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_avr_uart.sv
// Scoreboard bench for avr_uart: TX frames decoded off the line, RX bytes read back via UDR.
module tb_avr_uart;
  import avr_io_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] io_addr = '0;
  logic       io_read = 1'b0;
  logic       io_write = 1'b0;
  logic [7:0] io_din = '0;
  logic [7:0] io_dout;
  logic       rx = 1'b1;
  logic       tx;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;
  int frames = 0;
  logic mon_en = 1'b1;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int unsigned start_cyc[$];

  avr_uart #(.UBRR_INIT(8'd0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
    .io_din(io_din), .io_dout(io_dout), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk); io_addr = a; io_din = d; io_write = 1'b1;
    @(posedge clk); #1; io_write = 1'b0;
  endtask

  task automatic io_rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk); io_addr = a; io_read = 1'b1; #1; d = io_dout;
    @(posedge clk); #1; io_read = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [5:0] a, input logic [7:0] exp);
    io_addr = a; #1;
    check(tag, 32'(io_dout), 32'(exp));
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames < n && k < budget) begin @(posedge clk); k++; end
    check("tx_frames_seen", 32'(frames), 32'(n));
  endtask

  task automatic count_tx_low(input string tag, input int len);
    int lows = 0;
    repeat (len) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check(tag, 32'(lows), 32'd0);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(negedge clk); rx = 1'b0; repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (64) @(negedge clk); end
    rx = stop; repeat (64) @(negedge clk);
    rx = 1'b1; repeat (64) @(negedge clk);
  endtask

  // TX line monitor: decodes frames at 16 clocks/bit and pops the expected byte
  initial begin
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        repeat (8) @(negedge clk);
        check("tx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin repeat (16) @(negedge clk); b[i] = tx; end
        repeat (16) @(negedge clk);
        check("tx_stop_bit", 32'(tx), 32'd1);
        if (txq.size() == 0) check("tx_unexpected_frame", 32'(txq.size()), 32'd1);
        else check("tx_frame_data", 32'(b), 32'(txq.pop_front()));
        frames++;
      end
      prev = tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int base;
    repeat (3) @(posedge clk); #1;
    check("reset_tx", 32'(tx), 32'd1);
    chk_reg("reset_ucsra", ADDR_UCSRA, 8'h20);
    chk_reg("reset_ucsrb", ADDR_UCSRB, 8'h00);
    chk_reg("reset_ubrr", ADDR_UBRR, 8'h00);
    chk_reg("reset_udr", ADDR_UDR, 8'h00);
    chk_reg("unmapped_read", 6'h3F, 8'h00);
    @(negedge clk); rst = 1'b0;

    // UDR write with TXEN=0 is dropped
    io_wr(ADDR_UDR, 8'h99);
    chk_reg("udr_drop_txen0", ADDR_UCSRA, 8'h20);
    io_wr(ADDR_UBRR, 8'h03);
    chk_reg("ubrr_rw", ADDR_UBRR, 8'h03);
    io_wr(ADDR_UBRR, 8'h00);
    io_wr(ADDR_UCSRB, 8'h08);

    // Single frame 0x55: exact start latency and TXC at 160 clocks
    txq.push_back(8'h55);
    io_wr(ADDR_UDR, 8'h55);
    check("tx_high_at_write", 32'(tx), 32'd1);
    chk_reg("udre_clear_on_write", ADDR_UCSRA, 8'h00);
    @(posedge clk); #1;
    check("tx_start_1clk", 32'(tx), 32'd0);
    chk_reg("udre_set_on_load", ADDR_UCSRA, 8'h20);
    repeat (159) @(posedge clk); #1;
    chk_reg("txc_not_yet", ADDR_UCSRA, 8'h20);
    @(posedge clk); #1;
    chk_reg("txc_at_160", ADDR_UCSRA, 8'h60);
    wait_frames(1, 50);
    io_wr(ADDR_UCSRA, 8'h40);
    chk_reg("txc_w1c", ADDR_UCSRA, 8'h20);

    // Back-to-back frames; third write while UDRE=0 is dropped
    base = start_cyc.size();
    txq.push_back(8'hA3);
    io_wr(ADDR_UDR, 8'hA3);
    @(posedge clk); #1;
    txq.push_back(8'h3C);
    io_wr(ADDR_UDR, 8'h3C);
    chk_reg("udre_holding_full", ADDR_UCSRA, 8'h00);
    io_wr(ADDR_UDR, 8'hFF);
    wait_frames(3, 600);
    if (start_cyc.size() >= base + 2)
      check("tx_back_to_back_gap", start_cyc[base+1] - start_cyc[base], 32'd160);
    else
      check("tx_back_to_back_starts", 32'(start_cyc.size()), 32'(base + 2));
    count_tx_low("tx_third_write_dropped", 300);
    check("tx_queue_drained", 32'(txq.size()), 32'd0);

    // TXEN cleared mid-frame: current frame completes, held byte stays put
    txq.push_back(8'h0F);
    io_wr(ADDR_UDR, 8'h0F);
    @(posedge clk); #1;
    io_wr(ADDR_UDR, 8'hF0);
    repeat (40) @(posedge clk);
    io_wr(ADDR_UCSRB, 8'h00);
    wait_frames(4, 300);
    count_tx_low("tx_held_after_txen_clear", 400);
    chk_reg("ucsra_after_txen_clear", ADDR_UCSRA, 8'h40);

    // Reset mid-frame: re-enabling TXEN launches the held byte, then reset hits
    mon_en = 1'b0;
    io_wr(ADDR_UCSRB, 8'h08);
    repeat (50) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_midframe_tx", 32'(tx), 32'd1);
    chk_reg("rst_midframe_ucsra", ADDR_UCSRA, 8'h20);
    chk_reg("rst_midframe_ucsrb", ADDR_UCSRB, 8'h00);
    @(negedge clk); rst = 1'b0;
    count_tx_low("no_frame_after_reset", 300);
    mon_en = 1'b1;

`ifdef AVR_UART_RX_EN
    io_wr(ADDR_UBRR, 8'h03);
    io_wr(ADDR_UCSRB, 8'h18);
    chk_reg("ucsrb_rx_build", ADDR_UCSRB, 8'h18);
    rxq.push_back(8'hC9);
    rx_send(8'hC9, 1'b1);
    chk_reg("rxc_set", ADDR_UCSRA, 8'hA0);
    io_rd(ADDR_UDR, d);
    if (rxq.size() == 0) check("rx_queue_empty", 32'(rxq.size()), 32'd1);
    else check("rx_byte_c9", 32'(d), 32'(rxq.pop_front()));
    chk_reg("rxc_clear_on_read", ADDR_UCSRA, 8'h20);

    rxq.push_back(8'h11);
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    chk_reg("dor_set", ADDR_UCSRA, 8'hA8);
    io_rd(ADDR_UDR, d);
    if (rxq.size() == 0) check("rx_queue_empty", 32'(rxq.size()), 32'd1);
    else check("rx_first_retained", 32'(d), 32'(rxq.pop_front()));
    chk_reg("dor_clear_on_read", ADDR_UCSRA, 8'h20);

    rxq.push_back(8'h5A);
    rx_send(8'h5A, 1'b0);
    chk_reg("fe_set", ADDR_UCSRA, 8'hB0);
    io_rd(ADDR_UDR, d);
    if (rxq.size() == 0) check("rx_queue_empty", 32'(rxq.size()), 32'd1);
    else check("rx_byte_5a", 32'(d), 32'(rxq.pop_front()));
    chk_reg("fe_clear_on_read", ADDR_UCSRA, 8'h20);

    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk_reg("false_start_no_rxc", ADDR_UCSRA, 8'h20);
`else
    io_wr(ADDR_UCSRB, 8'h18);
    chk_reg("ucsrb_no_rx", ADDR_UCSRB, 8'h08);
    @(negedge clk); rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk_reg("rx_ignored_ucsra", ADDR_UCSRA, 8'h20);
    chk_reg("rx_ignored_udr", ADDR_UDR, 8'h00);
    check("rx_queue_unused", 32'(rxq.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avr_uart.md
AVR_UART -- requirements
Module: avr_uart

Interface
REQ-001 Parameter UBRR_INIT, 8'd0, reset value of the UBRR baud register.
REQ-002 Parameter SYNC_STAGES, 2, number of rx synchroniser flops (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 io_addr  input  6  CPU IO address.
REQ-006 io_read  input  1  CPU IO read strobe, one cycle.
REQ-007 io_write  input  1  CPU IO write strobe, one cycle.
REQ-008 io_din  input  8  write data, driven by the CPU io_out.
REQ-009 io_dout  output  8  read data to the CPU io_in; combinational from io_addr; 0 for unmapped addresses.
REQ-010 rx  input  1  serial in, asynchronous.
REQ-011 tx  output  1  serial out, registered, idle high.

Function
REQ-012 Register map: UDR 0x0C, UCSRA 0x0B, UCSRB 0x0A, UBRR 0x09; other addresses are ignored on write.
REQ-013 UCSRA bits: 7 RXC, 6 TXC, 5 UDRE, 4 FE, 3 DOR; all other bits read 0 and are read-only except TXC.
REQ-014 Writing 1 to UCSRA bit 6 shall clear TXC; all other UCSRA writes have no effect.
REQ-015 UCSRB bits: 4 RXEN, 3 TXEN; read/write; other bits read 0.
REQ-016 Baud tick shall pulse for one clk every UBRR+1 clocks; one serial bit = 16 ticks; the prescaler reloads when UBRR is written.
REQ-017 Frame format shall be fixed 8N1, LSB first.
REQ-018 UDR write with UDRE=1 and TXEN=1 shall load the holding register and clear UDRE; writes in any other case are dropped.
REQ-019 TX FSM states: IDLE, START, DATA, STOP.
REQ-020 In IDLE with the holding register full, the shifter shall load on the next clock: UDRE=1, state START, tx=0 from that edge.
REQ-021 START/DATA/STOP last 16 ticks each; DATA shifts 8 bits; at the end of STOP, TXC=1 and the FSM goes to IDLE, or back to START if the holding register is full (back-to-back frames).
REQ-022 Clearing TXEN mid-frame shall let the current frame complete, then hold tx=1.
REQ-023 RX FSM states: IDLE, START, DATA, STOP; it operates only when RXEN=1.
REQ-024 A synchronised falling edge in IDLE shall enter START; at tick 8 a high sample shall be a false start and return to IDLE.
REQ-025 Data bits shall be sampled at tick 8 of each bit.
REQ-026 Stop-bit sample at tick 8: the byte goes to the RX buffer and RXC is set; FE is set if stop=0, else FE is cleared.
REQ-027 If RXC is already 1 when a byte completes, the new byte shall be discarded and DOR set.
REQ-028 An io_read of UDR shall return the buffer and clear RXC, FE and DOR at the next edge.
REQ-029 If a UDR read and a byte completion coincide, the new byte shall be stored, RXC=1, DOR=0.
REQ-030 Clearing RXEN mid-frame shall abort to IDLE immediately without setting any flag.

Reset
REQ-031 On rst: tx=1; both FSMs IDLE; UDRE=1; RXC=TXC=FE=DOR=0; UCSRB=0; UBRR=UBRR_INIT; prescaler=0; RX buffer and holding register=0; synchronisers=1.
REQ-032 A reset asserted mid-frame shall take effect at the next edge, with no partial frame resumed afterwards.

Configuration
REQ-033 Macro AVR_UART_RX_EN: when defined, the receiver (REQ-023..030) is compiled in.
REQ-034 Without AVR_UART_RX_EN: no RX logic; rx is ignored; RXC, FE, DOR and RXEN read 0; UDR reads 0.

Structure
REQ-035 Package avr_io_pkg shall hold the register address constants, UCSRA/UCSRB bit positions, and the TX/RX state enum typedefs.
REQ-036 Sub-module avr_uart_baud shall implement the prescaler/tick generator; all other logic lives in avr_uart.

Verification
REQ-037 UBRR=0, TXEN=1, write UDR=0x55 -> tx low 1 clk later; bit period 16 clks; pattern 0,1,0,1,0,1,0,1,0,1; TXC=1 after 160 clks.
REQ-038 Write 0xA3 then 0x3C while UDRE=1 after the first load -> two back-to-back frames, no idle gap; third write while UDRE=0 dropped.
REQ-039 RXEN=1, UBRR=3, drive 0xC9 with stop=1 at 64 clks/bit -> RXC=1, UDR reads 0xC9, RXC=0 after read.
REQ-040 Two bytes received without a UDR read -> the first byte is retained, DOR=1; a 0 stop bit gives FE=1.
REQ-041 A 4-clk low glitch on rx with UBRR=3 -> false start, no RXC.
REQ-042 rst asserted mid-TX-frame -> tx=1, UDRE=1 next edge; the build without AVR_UART_RX_EN reads UCSRA=0x20 after reset.
